// File: rtl/pkt_pkg.sv
// pkt_pkg: shared word layout and arbiter state encodings
package pkt_pkg;
    localparam int PKT_W  = 36;
    localparam int SOP    = 35;
    localparam int EOP    = 34;
    localparam int MTY_HI = 33;
    localparam int MTY_LO = 32;
    localparam int DAT_HI = 31;
    typedef enum logic [1:0] {IDLE, SEND0, SEND1} arb_state_t;
endpackage

// File: rtl/pkt_arb_fifo.sv
// pkt_arb_fifo: store-and-forward port FIFO with show-ahead read and complete-packet count
module pkt_arb_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int AF_LVL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PKT_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [PKT_W-1:0] q,
    output logic             rdy,
    output logic             drop,
    output logic             req
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] RDY_LIM  = (AW+1)'(DEPTH - AF_LVL);
    logic [PKT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      used, used_nxt, pkt_cnt;
    logic             full, push, push_eop, pop_eop;
    // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign full     = used == FULL_CNT;
    assign push     = wr_en && (!full || rd_en);
    assign drop     = wr_en && full && !rd_en;
    assign used_nxt = used + (AW+1)'(push) - (AW+1)'(rd_en);
    assign push_eop = push && wr_data[EOP];
    assign pop_eop  = rd_en && q[EOP];
    assign q        = mem[rp];
    assign req      = pkt_cnt != '0;
    // pointers, occupancy, complete-packet count and registered almost-full guard
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            used    <= '0;
            pkt_cnt <= '0;
            rdy     <= 1'b0;
        end else begin
            wp      <= wp + AW'(push);
            rp      <= rp + AW'(rd_en);
            used    <= used_nxt;
            pkt_cnt <= pkt_cnt + (AW+1)'(push_eop) - (AW+1)'(pop_eop);
            rdy     <= used_nxt < RDY_LIM;
        end
    end
    // storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/pkt_arb2.sv
// pkt_arb2: two-port round-robin packet arbiter onto one 32-bit stream
module pkt_arb2
    import pkt_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    parameter int AF_LVL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din0,
    input  logic        din0_vld,
    input  logic        din0_sop,
    input  logic        din0_eop,
    input  logic [1:0]  din0_mty,
    output logic        rdy0,
    output logic        ovf0,
    input  logic [31:0] din1,
    input  logic        din1_vld,
    input  logic        din1_sop,
    input  logic        din1_eop,
    input  logic [1:0]  din1_mty,
    output logic        rdy1,
    output logic        ovf1,
    output logic [31:0] dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic [1:0]  dout_mty,
    output logic        dout_port,
    input  logic        b_rdy
);
    arb_state_t       state, state_nxt;
    logic             last_grant, lg_nxt, grant1;
    logic             pop0, pop1, drop0, drop1, req0, req1;
    logic [PKT_W-1:0] q0, q1, sel;
    pkt_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LVL(AF_LVL)) u_fifo0 (
        .clk(clk), .rst(rst), .wr_en(din0_vld), .wr_data({din0_sop, din0_eop, din0_mty, din0}),
        .rd_en(pop0), .q(q0), .rdy(rdy0), .drop(drop0), .req(req0)
    );
    pkt_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LVL(AF_LVL)) u_fifo1 (
        .clk(clk), .rst(rst), .wr_en(din1_vld), .wr_data({din1_sop, din1_eop, din1_mty, din1}),
        .rd_en(pop1), .q(q1), .rdy(rdy1), .drop(drop1), .req(req1)
    );
    assign grant1 = req1 && (!last_grant || !req0);
    assign sel    = pop1 ? q1 : q0;
    // arbiter state and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= lg_nxt;
        end
    end
    // grant whole packets; leave a send state on the edge that pops the eop word
    always_comb begin
        state_nxt = state;
        lg_nxt    = last_grant;
        pop0      = 1'b0;
        pop1      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = grant1 ? SEND1 : SEND0;
                    lg_nxt    = grant1;
                end
            end
            SEND0: begin
                pop0      = b_rdy;
                state_nxt = (b_rdy && q0[EOP]) ? IDLE : SEND0;
            end
            SEND1: begin
                pop1      = b_rdy;
                state_nxt = (b_rdy && q1[EOP]) ? IDLE : SEND1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // output register loads the popped word; fields hold while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout_mty  <= '0;
            dout_port <= 1'b0;
            ovf0      <= 1'b0;
            ovf1      <= 1'b0;
        end else begin
            dout_vld <= pop0 || pop1;
            ovf0     <= drop0;
            ovf1     <= drop1;
            if (pop0 || pop1) begin
                dout      <= sel[DAT_HI:0];
                dout_sop  <= sel[SOP];
                dout_eop  <= sel[EOP];
                dout_mty  <= sel[MTY_HI:MTY_LO];
                dout_port <= pop1;
            end
        end
    end
endmodule

// File: tb/tb_pkt_arb2.sv
// tb_pkt_arb2: directed scenario bench for the two-port packet arbiter
module tb_pkt_arb2;
    logic        clk = 1'b0, rst = 1'b1, b_rdy = 1'b1;
    logic [31:0] din0 = '0, din1 = '0;
    logic        din0_vld = 1'b0, din0_sop = 1'b0, din0_eop = 1'b0;
    logic        din1_vld = 1'b0, din1_sop = 1'b0, din1_eop = 1'b0;
    logic [1:0]  din0_mty = '0, din1_mty = '0;
    logic        rdy0, ovf0, rdy1, ovf1;
    logic [31:0] dout;
    logic        dout_vld, dout_sop, dout_eop, dout_port;
    logic [1:0]  dout_mty;
    int          cyc = 0, checks = 0, fails = 0;
    logic [36:0] cap[$];
    int          capc[$];

    pkt_arb2 dut (
        .clk(clk), .rst(rst),
        .din0(din0), .din0_vld(din0_vld), .din0_sop(din0_sop), .din0_eop(din0_eop), .din0_mty(din0_mty),
        .rdy0(rdy0), .ovf0(ovf0),
        .din1(din1), .din1_vld(din1_vld), .din1_sop(din1_sop), .din1_eop(din1_eop), .din1_mty(din1_mty),
        .rdy1(rdy1), .ovf1(ovf1),
        .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_mty(dout_mty), .dout_port(dout_port), .b_rdy(b_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dout_vld) begin
            cap.push_back({dout_port, dout_sop, dout_eop, dout_mty, dout});
            capc.push_back(cyc);
        end
    end

    function automatic logic [36:0] w(input bit p, input bit s, input bit e, input logic [1:0] m, input logic [31:0] d);
        return {p, s, e, m, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic [31:0] d, input bit s, input bit e, input logic [1:0] m);
        if (p) begin
            din1 = d; din1_sop = s; din1_eop = e; din1_mty = m; din1_vld = 1'b1;
        end else begin
            din0 = d; din0_sop = s; din0_eop = e; din0_mty = m; din0_vld = 1'b1;
        end
        tick;
        din0_vld = 1'b0;
        din1_vld = 1'b0;
    endtask

    task automatic drive2(input logic [31:0] d0, input bit s0, input bit e0, input logic [1:0] m0,
                          input logic [31:0] d1, input bit s1, input bit e1, input logic [1:0] m1);
        din0 = d0; din0_sop = s0; din0_eop = e0; din0_mty = m0; din0_vld = 1'b1;
        din1 = d1; din1_sop = s1; din1_eop = e1; din1_mty = m1; din1_vld = 1'b1;
        tick;
        din0_vld = 1'b0;
        din1_vld = 1'b0;
    endtask

    task automatic wait_cap(input int n);
        int k;
        k = 0;
        while (cap.size() < n && k < 300) begin
            tick;
            k++;
        end
        checks++;
        if (cap.size() < n) begin
            fails++;
            $display("FAIL wait_cap: got %0d words, need %0d", cap.size(), n);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        cap.delete();
        capc.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b_rdy = 1'b1;
        tick;
        tick;
        checks++;
        if ({dout_vld, dout_sop, dout_eop, dout_mty, dout_port, rdy0, rdy1, ovf0, ovf1} !== 10'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, want 0", {dout_vld, dout_sop, dout_eop, dout_mty, dout_port, rdy0, rdy1, ovf0, ovf1});
        end
        checks++;
        if (dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_dout: got %h, want 0", dout);
        end
        rst = 1'b0;
        tick;
        checks++;
        if ({rdy0, rdy1} !== 2'b11) begin
            fails++;
            $display("FAIL reset_rdy_release: got %b, want 11", {rdy0, rdy1});
        end
        cap.delete();
        capc.delete();
    endtask

    task automatic test_single;
        logic [36:0] exp [3];
        int te;
        exp = '{w(0, 1, 0, 0, 32'hA0A0_0000), w(0, 0, 0, 0, 32'hA0A0_0001), w(0, 0, 1, 2, 32'hA0A0_0002)};
        drive(0, 32'hA0A0_0000, 1, 0, 0);
        drive(0, 32'hA0A0_0001, 0, 0, 0);
        te = cyc;
        drive(0, 32'hA0A0_0002, 0, 1, 2);
        wait_cap(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                fails++;
                $display("FAIL single_word%0d: got %h, want %h", i, cap[i], exp[i]);
            end
        end
        checks++;
        if (capc[0] !== te + 3) begin
            fails++;
            $display("FAIL single_latency: got cycle %0d, want %0d", capc[0], te + 3);
        end
    endtask

    task automatic test_two_ports;
        logic [36:0] exp [8];
        do_reset;
        exp = '{w(0, 1, 0, 0, 32'h10), w(0, 0, 1, 0, 32'h11),
                w(1, 1, 0, 0, 32'h20), w(1, 0, 1, 0, 32'h21),
                w(0, 1, 0, 0, 32'h12), w(0, 0, 1, 1, 32'h13),
                w(1, 1, 0, 0, 32'h22), w(1, 0, 1, 3, 32'h23)};
        drive2(32'h10, 1, 0, 0, 32'h20, 1, 0, 0);
        drive2(32'h11, 0, 1, 0, 32'h21, 0, 1, 0);
        drive2(32'h12, 1, 0, 0, 32'h22, 1, 0, 0);
        drive2(32'h13, 0, 1, 1, 32'h23, 0, 1, 3);
        wait_cap(8);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                fails++;
                $display("FAIL rr_word%0d: got %h, want %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_partial;
        logic [36:0] exp [6];
        cap.delete();
        exp = '{w(0, 1, 1, 0, 32'h40),
                w(1, 1, 0, 0, 32'h30), w(1, 0, 0, 0, 32'h31), w(1, 0, 0, 0, 32'h32),
                w(1, 0, 0, 0, 32'h33), w(1, 0, 1, 1, 32'h34)};
        drive(1, 32'h30, 1, 0, 0);
        drive(1, 32'h31, 0, 0, 0);
        drive(1, 32'h32, 0, 0, 0);
        drive(1, 32'h33, 0, 0, 0);
        drive(0, 32'h40, 1, 1, 0);
        wait_cap(1);
        repeat (10) tick;
        checks++;
        if (cap.size() !== 1) begin
            fails++;
            $display("FAIL partial_held: got %0d words, want 1", cap.size());
        end
        drive(1, 32'h34, 0, 1, 1);
        wait_cap(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                fails++;
                $display("FAIL partial_word%0d: got %h, want %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [36:0] exp [4];
        logic        seq [6];
        seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp = '{w(0, 1, 0, 0, 32'h50), w(0, 0, 0, 0, 32'h51), w(0, 0, 0, 0, 32'h52), w(0, 0, 1, 3, 32'h53)};
        b_rdy = 1'b0;
        cap.delete();
        drive(0, 32'h50, 1, 0, 0);
        drive(0, 32'h51, 0, 0, 0);
        drive(0, 32'h52, 0, 0, 0);
        drive(0, 32'h53, 0, 1, 3);
        tick;
        for (int i = 0; i < 6; i++) begin
            b_rdy = seq[i];
            tick;
            checks++;
            if (dout_vld !== seq[i]) begin
                fails++;
                $display("FAIL bp_vld%0d: got %b, want %b", i, dout_vld, seq[i]);
            end
        end
        b_rdy = 1'b1;
        wait_cap(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_word%0d: got %h, want %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_full;
        int used;
        do_reset;
        b_rdy = 1'b0;
        for (int i = 0; i < 66; i++) begin
            drive(0, 32'(i), i == 0, i == 63, 0);
            used = (i + 1 > 64) ? 64 : i + 1;
            checks++;
            if (rdy0 !== (used < 60)) begin
                fails++;
                $display("FAIL full_rdy%0d: got %b, want %b", i, rdy0, used < 60);
            end
            checks++;
            if (ovf0 !== (i >= 64)) begin
                fails++;
                $display("FAIL full_ovf%0d: got %b, want %b", i, ovf0, i >= 64);
            end
        end
        tick;
        checks++;
        if (ovf0 !== 1'b0) begin
            fails++;
            $display("FAIL full_ovf_end: got %b, want 0", ovf0);
        end
        b_rdy = 1'b1;
        wait_cap(64);
        repeat (5) tick;
        checks++;
        if (cap.size() !== 64) begin
            fails++;
            $display("FAIL full_count: got %0d words, want 64", cap.size());
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (cap[i] !== w(0, i == 0, i == 63, 0, 32'(i))) begin
                fails++;
                $display("FAIL full_word%0d: got %h, want %h", i, cap[i], w(0, i == 0, i == 63, 0, 32'(i)));
            end
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            fails++;
            $display("FAIL full_rdy_recover: got %b, want 1", rdy0);
        end
    endtask

    task automatic test_reset_mid;
        logic [36:0] exp [4];
        exp = '{w(0, 1, 0, 0, 32'h70), w(0, 0, 1, 0, 32'h71), w(1, 1, 0, 0, 32'h80), w(1, 0, 1, 2, 32'h81)};
        b_rdy = 1'b0;
        cap.delete();
        drive(0, 32'h60, 1, 0, 0);
        drive(0, 32'h61, 0, 0, 0);
        drive(0, 32'h62, 0, 0, 0);
        drive(0, 32'h63, 0, 1, 0);
        tick;
        b_rdy = 1'b1;
        tick;
        checks++;
        if (dout_vld !== 1'b1 || dout !== 32'h60) begin
            fails++;
            $display("FAIL mid_first_pop: got vld=%b dout=%h, want vld=1 dout=60", dout_vld, dout);
        end
        rst = 1'b1;
        b_rdy = 1'b0;
        tick;
        checks++;
        if ({dout_vld, dout_sop, dout_eop, dout_mty, dout_port, rdy0, rdy1, ovf0, ovf1} !== 10'b0 || dout !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got flags=%b dout=%h, want 0",
                     {dout_vld, dout_sop, dout_eop, dout_mty, dout_port, rdy0, rdy1, ovf0, ovf1}, dout);
        end
        rst = 1'b0;
        b_rdy = 1'b1;
        cap.delete();
        capc.delete();
        drive2(32'h70, 1, 0, 0, 32'h80, 1, 0, 0);
        drive2(32'h71, 0, 1, 0, 32'h81, 0, 1, 2);
        wait_cap(4);
        repeat (5) tick;
        checks++;
        if (cap.size() !== 4) begin
            fails++;
            $display("FAIL mid_count: got %0d words, want 4", cap.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
                fails++;
                $display("FAIL mid_word%0d: got %h, want %h", i, cap[i], exp[i]);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_two_ports;
        test_partial;
        test_backpressure;
        test_full;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
